// File: rtl/instr_execute_pkg.sv
// Shared EX-stage definitions: opcode map, ID/EX and EX/MEM layouts, FSM states.
package instr_execute_pkg;

   localparam int unsigned IDEX_W = 149;
   localparam int unsigned EXM_W  = 77;

   localparam int unsigned EXM_RES_LSB   = 0;
   localparam int unsigned EXM_SDATA_LSB = 32;
   localparam int unsigned EXM_OP_LSB    = 64;
   localparam int unsigned EXM_RD_LSB    = 70;
   localparam int unsigned EXM_VALID_BIT = 75;
   localparam int unsigned EXM_WE_BIT    = 76;

   localparam logic [5:0] OP_LUI   = 6'd0;
   localparam logic [5:0] OP_AUIPC = 6'd1;
   localparam logic [5:0] OP_JAL   = 6'd2;
   localparam logic [5:0] OP_JALR  = 6'd3;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_BNE   = 6'd5;
   localparam logic [5:0] OP_BLT   = 6'd6;
   localparam logic [5:0] OP_BGE   = 6'd7;
   localparam logic [5:0] OP_BLTU  = 6'd8;
   localparam logic [5:0] OP_BGEU  = 6'd9;
   localparam logic [5:0] OP_LB    = 6'd10;
   localparam logic [5:0] OP_LH    = 6'd11;
   localparam logic [5:0] OP_LW    = 6'd12;
   localparam logic [5:0] OP_LBU   = 6'd13;
   localparam logic [5:0] OP_LHU   = 6'd14;
   localparam logic [5:0] OP_SB    = 6'd15;
   localparam logic [5:0] OP_SH    = 6'd16;
   localparam logic [5:0] OP_SW    = 6'd17;
   localparam logic [5:0] OP_ADDI  = 6'd18;
   localparam logic [5:0] OP_SLTI  = 6'd19;
   localparam logic [5:0] OP_SLTIU = 6'd20;
   localparam logic [5:0] OP_XORI  = 6'd21;
   localparam logic [5:0] OP_ORI   = 6'd22;
   localparam logic [5:0] OP_ANDI  = 6'd23;
   localparam logic [5:0] OP_SLLI  = 6'd24;
   localparam logic [5:0] OP_SRLI  = 6'd25;
   localparam logic [5:0] OP_SRAI  = 6'd26;
   localparam logic [5:0] OP_ADD   = 6'd27;
   localparam logic [5:0] OP_SUB   = 6'd28;
   localparam logic [5:0] OP_SLL   = 6'd29;
   localparam logic [5:0] OP_SLT   = 6'd30;
   localparam logic [5:0] OP_SLTU  = 6'd31;
   localparam logic [5:0] OP_XOR   = 6'd32;
   localparam logic [5:0] OP_SRL   = 6'd33;
   localparam logic [5:0] OP_SRA   = 6'd34;
   localparam logic [5:0] OP_OR    = 6'd35;
   localparam logic [5:0] OP_AND   = 6'd36;

   typedef enum logic {S_RUN, S_LDWAIT} state_t;

   typedef struct packed {
      logic [31:0] rv2;
      logic [31:0] rv1;
      logic [4:0]  rd;
      logic [4:0]  rs2;
      logic [4:0]  rs1;
      logic [5:0]  opcode;
      logic [31:0] imm;
      logic [31:0] pc;
   } id_ex_t;

   typedef struct packed {
      logic        we;
      logic        valid;
      logic [4:0]  rd;
      logic [5:0]  opcode;
      logic [31:0] sdata;
      logic [31:0] result;
   } ex_mem_t;

   function automatic logic is_branch(input logic [5:0] op);
      return (op >= OP_BEQ) && (op <= OP_BGEU);
   endfunction

   function automatic logic is_load(input logic [5:0] op);
      return (op >= OP_LB) && (op <= OP_LHU);
   endfunction

   function automatic logic is_store(input logic [5:0] op);
      return (op >= OP_SB) && (op <= OP_SW);
   endfunction

   function automatic logic uses_rs1(input logic [5:0] op);
      return (op >= OP_JALR) && (op <= OP_AND);
   endfunction

   function automatic logic uses_rs2(input logic [5:0] op);
      return is_branch(op) || is_store(op) || ((op >= OP_ADD) && (op <= OP_AND));
   endfunction

endpackage

// File: rtl/instr_execute_alu.sv
// Combinational EX datapath: ALU result, branch decision and redirect target.
module ex_alu
   import instr_execute_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] imm,
   input  logic [31:0] pc,
   input  logic [5:0]  opcode,
   output logic [31:0] result,
   output logic        taken,
   output logic [31:0] target
);

   logic [31:0] sum_ai;
   logic [31:0] pc_imm;
   logic [4:0]  sh_i;
   logic [4:0]  sh_r;

   assign sum_ai = a + imm;
   assign pc_imm = pc + imm;
   assign sh_i   = imm[4:0];
   assign sh_r   = b[4:0];

   always_comb begin
      result = '0;
      taken  = 1'b0;
      target = pc_imm;
      case (opcode)
         OP_LUI:   result = imm;
         OP_AUIPC: result = pc_imm;
         OP_JAL:   begin result = pc + 32'd4; taken = 1'b1; end
         OP_JALR:  begin result = pc + 32'd4; taken = 1'b1; target = sum_ai & ~32'd1; end
         OP_BEQ:   taken = (a == b);
         OP_BNE:   taken = (a != b);
         OP_BLT:   taken = ($signed(a) <  $signed(b));
         OP_BGE:   taken = ($signed(a) >= $signed(b));
         OP_BLTU:  taken = (a <  b);
         OP_BGEU:  taken = (a >= b);
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
         OP_SB, OP_SH, OP_SW,
         OP_ADDI:  result = sum_ai;
         OP_SLTI:  result = {31'd0, $signed(a) < $signed(imm)};
         OP_SLTIU: result = {31'd0, a < imm};
         OP_XORI:  result = a ^ imm;
         OP_ORI:   result = a | imm;
         OP_ANDI:  result = a & imm;
         OP_SLLI:  result = a << sh_i;
         OP_SRLI:  result = a >> sh_i;
         OP_SRAI:  result = 32'($signed(a) >>> sh_i);
         OP_ADD:   result = a + b;
         OP_SUB:   result = a - b;
         OP_SLL:   result = a << sh_r;
         OP_SLT:   result = {31'd0, $signed(a) < $signed(b)};
         OP_SLTU:  result = {31'd0, a < b};
         OP_XOR:   result = a ^ b;
         OP_SRL:   result = a >> sh_r;
         OP_SRA:   result = 32'($signed(a) >>> sh_r);
         OP_OR:    result = a | b;
         OP_AND:   result = a & b;
         default:  ;
      endcase
   end

endmodule

// File: rtl/instr_execute.sv
// EX stage: operand forwarding, load-use interlock, branch shadow squash and EX/MEM register.
module instr_execute
   import instr_execute_pkg::*;
#(
   parameter int unsigned BRANCH_SHADOW = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [IDEX_W-1:0]   reg_id_ex,
   input  logic                id_ex_valid,
   input  logic                mem_stall,
   input  logic                wb_we,
   input  logic [4:0]          wb_rd,
   input  logic [31:0]         wb_data,
   output logic [EXM_W-1:0]    reg_ex_mem,
   output logic                stall_req,
   output logic                redirect,
   output logic [31:0]         redirect_pc
);

   id_ex_t      idx;
   ex_mem_t     exm_q, exm_d;
   state_t      state, state_nxt;
   logic [1:0]  sq_cnt, sq_nxt;
   logic        redirect_nxt;
   logic [31:0] redirect_pc_nxt;
   logic [31:0] op_a, op_b;
   logic [31:0] alu_res, alu_target;
   logic        alu_taken;
   logic        exm_fwd, exm_load, live, hazard;

   assign idx        = reg_id_ex;
   assign reg_ex_mem = exm_q;

   // Loads are not forwarded from EX/MEM: their data only exists from WB onwards.
   assign exm_fwd  = exm_q.valid && exm_q.we && !is_load(exm_q.opcode);
   assign exm_load = exm_q.valid && is_load(exm_q.opcode) && (exm_q.rd != '0);
   assign live     = id_ex_valid && (sq_cnt == '0);
   assign hazard   = (state == S_RUN) && live && exm_load &&
                     ((uses_rs1(idx.opcode) && (idx.rs1 == exm_q.rd)) ||
                      (uses_rs2(idx.opcode) && (idx.rs2 == exm_q.rd)));

   always_comb begin
      op_a = idx.rv1;
      if (idx.rs1 != '0) begin
         if (exm_fwd && (exm_q.rd == idx.rs1))  op_a = exm_q.result;
         else if (wb_we && (wb_rd == idx.rs1))  op_a = wb_data;
      end
      op_b = idx.rv2;
      if (idx.rs2 != '0) begin
         if (exm_fwd && (exm_q.rd == idx.rs2))  op_b = exm_q.result;
         else if (wb_we && (wb_rd == idx.rs2))  op_b = wb_data;
      end
   end

   ex_alu u_alu (
      .a      (op_a),
      .b      (op_b),
      .imm    (idx.imm),
      .pc     (idx.pc),
      .opcode (idx.opcode),
      .result (alu_res),
      .taken  (alu_taken),
      .target (alu_target)
   );

   always_comb begin
      state_nxt       = state;
      stall_req       = mem_stall;
      exm_d           = exm_q;
      sq_nxt          = sq_cnt;
      redirect_nxt    = 1'b0;
      redirect_pc_nxt = redirect_pc;
      if (!mem_stall) begin
         exm_d = '0;
         if (sq_cnt != '0) sq_nxt = sq_cnt - 2'd1;
         if (hazard) begin
            stall_req = 1'b1;
            state_nxt = S_LDWAIT;
         end else begin
            state_nxt = S_RUN;
            if (live) begin
               exm_d.valid  = 1'b1;
               exm_d.we     = !is_branch(idx.opcode) && !is_store(idx.opcode) && (idx.rd != '0);
               exm_d.rd     = idx.rd;
               exm_d.opcode = idx.opcode;
               exm_d.sdata  = op_b;
               exm_d.result = alu_res;
               if (alu_taken) begin
                  redirect_nxt    = 1'b1;
                  redirect_pc_nxt = alu_target;
                  sq_nxt          = 2'(BRANCH_SHADOW);
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_RUN;
         sq_cnt      <= '0;
         exm_q       <= '0;
         redirect    <= 1'b0;
         redirect_pc <= '0;
      end else begin
         state       <= state_nxt;
         sq_cnt      <= sq_nxt;
         exm_q       <= exm_d;
         redirect    <= redirect_nxt;
         redirect_pc <= redirect_pc_nxt;
      end
   end

endmodule

// File: tb/tb_instr_execute.sv
// Directed scoreboard bench for instr_execute: forwarding, load-use, shadow, stalls, reset.
module tb_instr_execute;
   import instr_execute_pkg::*;

   logic              clk;
   logic              rst;
   logic [IDEX_W-1:0] reg_id_ex;
   logic              id_ex_valid;
   logic              mem_stall;
   logic              wb_we;
   logic [4:0]        wb_rd;
   logic [31:0]       wb_data;
   logic [EXM_W-1:0]  reg_ex_mem;
   logic              stall_req;
   logic              redirect;
   logic [31:0]       redirect_pc;

   typedef struct {
      string       tag;
      logic        v;
      logic        we;
      logic        chk_res;
      logic [31:0] res;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   instr_execute #(.BRANCH_SHADOW(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .reg_id_ex   (reg_id_ex),
      .id_ex_valid (id_ex_valid),
      .mem_stall   (mem_stall),
      .wb_we       (wb_we),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .reg_ex_mem  (reg_ex_mem),
      .stall_req   (stall_req),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [76:0] got, input logic [76:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic [31:0] pc, input logic [31:0] imm, input logic [5:0] op,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [31:0] rv1, input logic [31:0] rv2);
      reg_id_ex   = {rv2, rv1, rd, rs2, rs1, op, imm, pc};
      id_ex_valid = 1'b1;
   endtask

   task automatic expect_out(input string tag, input logic v, input logic we,
                             input logic chk_res, input logic [31:0] res);
      exp_t e;
      e.tag = tag; e.v = v; e.we = we; e.chk_res = chk_res; e.res = res;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL sb_underrun: got empty queue expected entry");
      end else begin
         e = exp_q.pop_front();
         check({e.tag, ".valid"}, 77'(reg_ex_mem[EXM_VALID_BIT]), 77'(e.v));
         check({e.tag, ".we"}, 77'(reg_ex_mem[EXM_WE_BIT]), 77'(e.we));
         if (e.chk_res)
            check({e.tag, ".result"}, 77'(reg_ex_mem[EXM_RES_LSB +: 32]), 77'(e.res));
      end
   endtask

   task automatic check_stall(input string tag, input logic exp);
      #1;
      check(tag, 77'(stall_req), 77'(exp));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; reg_id_ex = '0; id_ex_valid = 1'b0; mem_stall = 1'b0;
      wb_we = 1'b0; wb_rd = '0; wb_data = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst.word", reg_ex_mem, '0);
      check("rst.redirect", 77'(redirect), 77'(0));
      check("rst.redirect_pc", 77'(redirect_pc), 77'(0));
      check("rst.stall_req", 77'(stall_req), 77'(0));
      rst = 1'b0;

      // EX/MEM forwarding, stale register values deliberately wrong
      issue(32'h10, 32'd5, OP_ADDI, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0);
      expect_out("addi", 1, 1, 1, 32'd5); tick();
      issue(32'h14, 32'd0, OP_ADD, 5'd1, 5'd1, 5'd2, 32'hDEAD0000, 32'hDEAD0000);
      expect_out("add_fwd", 1, 1, 1, 32'd10); tick();

      // Load-use: one bubble, then WB forwarding
      issue(32'h18, 32'h100, OP_LW, 5'd0, 5'd0, 5'd3, 32'h0, 32'h0);
      check_stall("lw.stall", 0);
      expect_out("lw", 1, 1, 1, 32'h100); tick();
      issue(32'h1C, 32'd0, OP_ADD, 5'd3, 5'd3, 5'd4, 32'h55555555, 32'h55555555);
      check_stall("lu.stall", 1);
      expect_out("lu_bubble", 0, 0, 0, 32'd0); tick();
      wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'd7;
      check_stall("lu.release", 0);
      expect_out("lu_add", 1, 1, 1, 32'd14); tick();
      wb_we = 1'b0;

      // Taken BEQ and its two-instruction shadow, with a jump inside it
      issue(32'h40, 32'h10, OP_BEQ, 5'd5, 5'd6, 5'd0, 32'h1234, 32'h1234);
      expect_out("beq", 1, 0, 1, 32'd0); tick();
      check("beq.redirect", 77'(redirect), 77'(1));
      check("beq.redirect_pc", 77'(redirect_pc), 77'(32'h50));
      issue(32'h44, 32'd1, OP_ADDI, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0);
      expect_out("shadow1", 0, 0, 0, 32'd0); tick();
      check("beq.pulse", 77'(redirect), 77'(0));
      issue(32'h80, 32'h40, OP_JAL, 5'd0, 5'd0, 5'd8, 32'h0, 32'h0);
      expect_out("shadow2", 0, 0, 0, 32'd0); tick();
      check("shadow_jal.redirect", 77'(redirect), 77'(0));
      issue(32'h50, 32'd3, OP_ADDI, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0);
      expect_out("post_shadow", 1, 1, 1, 32'd3); tick();

      // JALR target alignment, rd=0 suppresses write
      issue(32'h200, 32'd0, OP_JALR, 5'd9, 5'd0, 5'd0, 32'h1003, 32'h0);
      expect_out("jalr", 1, 0, 1, 32'h204); tick();
      check("jalr.redirect", 77'(redirect), 77'(1));
      check("jalr.redirect_pc", 77'(redirect_pc), 77'(32'h1002));
      for (int i = 0; i < 2; i++) begin
         issue(32'h204 + 32'(4 * i), 32'd1, OP_ADDI, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0);
         expect_out("jalr_shadow", 0, 0, 0, 32'd0); tick();
      end

      issue(32'h1002, 32'd0, OP_SRA, 5'd10, 5'd11, 5'd12, 32'h80000000, 32'd31);
      expect_out("sra", 1, 1, 1, 32'hFFFFFFFF); tick();
      issue(32'h1006, 32'd0, OP_SLTU, 5'd13, 5'd14, 5'd15, 32'd1, 32'hFFFFFFFF);
      expect_out("sltu", 1, 1, 1, 32'd1); tick();

      // mem_stall holds the output word for 3 cycles
      mem_stall = 1'b1;
      issue(32'h100A, 32'd9, OP_ADDI, 5'd0, 5'd0, 5'd16, 32'h0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         check_stall("mstall.stall_req", 1);
         expect_out("mstall_hold", 1, 1, 1, 32'd1); tick();
      end
      mem_stall = 1'b0;
      expect_out("mstall_rel", 1, 1, 1, 32'd9); tick();

      // mem_stall right after a jump: no re-pulse, shadow counter frozen
      issue(32'h300, 32'h20, OP_JAL, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0);
      expect_out("jal", 1, 1, 1, 32'h304); tick();
      check("jal.redirect", 77'(redirect), 77'(1));
      mem_stall = 1'b1;
      issue(32'h304, 32'd2, OP_ADDI, 5'd0, 5'd0, 5'd17, 32'h0, 32'h0);
      for (int i = 0; i < 2; i++) begin
         expect_out("jal_hold", 1, 1, 1, 32'h304); tick();
         check("jal_hold.redirect", 77'(redirect), 77'(0));
         check("jal_hold.redirect_pc", 77'(redirect_pc), 77'(32'h320));
      end
      mem_stall = 1'b0;
      expect_out("jal_shadow1", 0, 0, 0, 32'd0); tick();
      expect_out("jal_shadow2", 0, 0, 0, 32'd0); tick();
      issue(32'h320, 32'd6, OP_ADDI, 5'd0, 5'd0, 5'd17, 32'h0, 32'h0);
      expect_out("jal_after", 1, 1, 1, 32'd6); tick();

      // Reset during a taken jump drops the redirect and the shadow
      issue(32'h400, 32'd8, OP_JAL, 5'd0, 5'd0, 5'd2, 32'h0, 32'h0);
      rst = 1'b1;
      expect_out("rst_mid", 0, 0, 1, 32'd0); tick();
      check("rst_mid.redirect", 77'(redirect), 77'(0));
      rst = 1'b0;
      issue(32'h404, 32'd4, OP_ADDI, 5'd0, 5'd0, 5'd5, 32'h0, 32'h0);
      expect_out("rst_after", 1, 1, 1, 32'd4); tick();

      // Load-use on a taken branch: stall first, branch resolves in LDWAIT
      issue(32'h500, 32'h100, OP_LW, 5'd0, 5'd0, 5'd3, 32'h0, 32'h0);
      expect_out("lw2", 1, 1, 1, 32'h100); tick();
      issue(32'h504, 32'h20, OP_BNE, 5'd3, 5'd0, 5'd0, 32'h0, 32'h0);
      check_stall("lubr.stall", 1);
      expect_out("lubr_bubble", 0, 0, 0, 32'd0); tick();
      check("lubr.no_redirect", 77'(redirect), 77'(0));
      wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'd7;
      check_stall("lubr.release", 0);
      expect_out("lubr_bne", 1, 0, 1, 32'd0); tick();
      check("lubr.redirect", 77'(redirect), 77'(1));
      check("lubr.redirect_pc", 77'(redirect_pc), 77'(32'h524));
      wb_we = 1'b0;
      id_ex_valid = 1'b0;
      expect_out("idle", 0, 0, 0, 32'd0); tick();
      check("sb_drained", 77'(exp_q.size()), 77'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
